ttlc_icu: RTL
=============

TTLC_ICU -- requirements
Module: ttlc_icu

Interface
REQ-001 Parameter RESET_PC, default 8'h00: program counter value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 4: return stack entries; used only with TTLC_ICU_STACK_EN.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  1 = execute program; 0 = halt after current instruction.
REQ-006 prog_addr  output  8  program memory address, equal to pc.
REQ-007 prog_re  output  1  program read strobe; memory returns prog_data one cycle later.
REQ-008 prog_data  input  12  instruction: [11:8] opcode, [7:0] operand address.
REQ-009 io_addr  output  8  I/O bit address, equal to IR[7:0].
REQ-010 io_we  output  1  single-cycle I/O bit write strobe.
REQ-011 io_wdata  output  1  I/O write data.
REQ-012 io_rdata  input  1  I/O read bit for io_addr, combinational from the I/O block.
REQ-013 rr  output  1  result register, fed to the I/O block's rr readback.
REQ-014 ien, oen  output  1 each  input-enable and output-enable latches.
REQ-015 flag_o, flag_f, jmp_p, rtn_p  output  1 each  single-cycle pulses for NOPO, NOPF, JMP, RTN.
REQ-016 halted  output  1  1 while in IDLE.

Function
REQ-017 FSM states IDLE, FETCH, LOAD, EXEC; each instruction takes exactly 3 cycles.
- IDLE->FETCH when run=1; FETCH->LOAD; LOAD->EXEC; EXEC->FETCH if run=1, else IDLE.
REQ-018 FETCH: prog_re=1. LOAD: IR<=prog_data. EXEC: decode IR; outputs, RR and pc update at the end of EXEC.
REQ-019 Effective data D = io_rdata & ien.
REQ-020 Opcodes: 0 NOPO (flag_o), 1 LD RR<=D, 2 LDC RR<=~D, 3 AND RR<=RR&D, 4 ANDC RR<=RR&~D, 5 OR RR<=RR|D, 6 ORC RR<=RR|~D, 7 XNOR RR<=~(RR^D).
REQ-021 Opcodes continued: 8 STO, 9 STOC, A IEN ien<=io_rdata, B OEN oen<=io_rdata, C JMP, D RTN, E SKZ, F NOPF (flag_f).
REQ-022 STO: io_we=oen, io_wdata=rr. STOC: io_we=oen, io_wdata=~rr. With oen=0 no write occurs.
REQ-023 io_we SHALL be asserted only in EXEC; io_addr SHALL hold IR[7:0] in all states.
REQ-024 pc increments by 1 mod 256 in EXEC (255 wraps to 0); JMP loads pc<=IR[7:0] and pulses jmp_p.
REQ-025 SKZ sets skip when rr=0; RTN sets skip and pulses rtn_p.
REQ-026 When skip=1, the next instruction is fetched but its EXEC is suppressed: no io_we, no RR/ien/oen/pc-load change, no pulses. pc still increments and skip clears.
REQ-027 run falling mid-instruction: the instruction completes through EXEC before IDLE. IDLE holds pc, rr, ien, oen and skip.

Reset
REQ-028 rst=1 asynchronously forces the following values:
- state=IDLE, pc=RESET_PC, IR=0, rr=0, skip=0, stack empty;
- ien=1, oen=1;
- io_we=0, prog_re=0 and all pulses 0.
REQ-029 Reset asserted mid-instruction aborts it; no io_we is generated in that cycle or after.

Configuration
REQ-030 Macro TTLC_ICU_STACK_EN, when defined, SHALL compile in a STACK_DEPTH-entry return stack.
REQ-031 With the stack, JMP pushes pc+1 and RTN pops it into pc, with no skip.
- A push when full overwrites the oldest entry.
- RTN when empty behaves as the no-stack RTN.
REQ-032 Without TTLC_ICU_STACK_EN, there are no stack registers; RTN only sets skip (REQ-025).

Verification
REQ-033 Reset, run=1, program {LD 0x30, STO 0x00}, io_rdata=1 -> rr=1 after cycle 3; io_we=1, io_addr=0x00, io_wdata=1 in cycle 6.
REQ-034 OEN with io_rdata=0, then STO 0x05 -> io_we stays 0; a later OEN with io_rdata=1, then STOC 0x05 with rr=1 -> io_we=1, io_wdata=0.
REQ-035 rr=0, SKZ, then STO 0x01, then NOPO -> no io_we; flag_o pulses once; pc advances by 3.
REQ-036 JMP 0x10 at pc 0xFF -> jmp_p=1 and pc=0x10; straight-line code at pc 0xFF -> pc=0x00.
REQ-037 rst pulsed during EXEC of STO -> io_we=0, halted=1, pc=RESET_PC, ien=oen=1.
REQ-038 With TTLC_ICU_STACK_EN: JMP 0x40 at pc 0x02, then RTN at 0x40 -> pc=0x03 and the next instruction executes (not skipped).

Source files
------------

// File: rtl/ttlc_icu.sv
// ttlc_icu: one-bit industrial control unit with a 3-cycle FETCH/LOAD/EXEC sequence.
// Define TTLC_ICU_STACK_EN to build in the STACK_DEPTH-entry JMP/RTN return stack.
module ttlc_icu #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  prog_addr,
  output logic        prog_re,
  input  logic [11:0] prog_data,
  output logic [7:0]  io_addr,
  output logic        io_we,
  output logic        io_wdata,
  input  logic        io_rdata,
  output logic        rr,
  output logic        ien,
  output logic        oen,
  output logic        flag_o,
  output logic        flag_f,
  output logic        jmp_p,
  output logic        rtn_p,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC} state_t;

  typedef enum logic [3:0] {
    OP_NOPO, OP_LD,  OP_LDC, OP_AND, OP_ANDC, OP_OR,  OP_ORC, OP_XNOR,
    OP_STO,  OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
  } op_t;

  if (STACK_DEPTH == 0) begin : g_bad_depth
    $error("STACK_DEPTH must be at least 1");
  end

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [11:0] ir_q;
  logic        rr_q, ien_q, oen_q, skip_q;
  logic        prog_re_q, io_we_q, io_wdata_q, halted_q;
  logic        flag_o_q, flag_f_q, jmp_p_q, rtn_p_q;

  op_t         op_ex, op_ld;
  logic        d_eff, rr_d;
  logic [7:0]  pc_inc;

`ifdef TTLC_ICU_STACK_EN
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  logic [7:0]    stk_q [STACK_DEPTH];
  logic [CW-1:0] stk_cnt_q;
`endif

  always_comb begin
    op_ex  = op_t'(ir_q[11:8]);
    op_ld  = op_t'(prog_data[11:8]);
    d_eff  = io_rdata & ien_q;
    pc_inc = pc_q + 8'd1;
    rr_d   = rr_q;
    case (op_ex)
      OP_LD:   rr_d = d_eff;
      OP_LDC:  rr_d = ~d_eff;
      OP_AND:  rr_d = rr_q & d_eff;
      OP_ANDC: rr_d = rr_q & ~d_eff;
      OP_OR:   rr_d = rr_q | d_eff;
      OP_ORC:  rr_d = rr_q | ~d_eff;
      OP_XNOR: rr_d = ~(rr_q ^ d_eff);
      default: rr_d = rr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      rr_q       <= 1'b0;
      ien_q      <= 1'b1;
      oen_q      <= 1'b1;
      skip_q     <= 1'b0;
      prog_re_q  <= 1'b0;
      io_we_q    <= 1'b0;
      io_wdata_q <= 1'b0;
      halted_q   <= 1'b1;
      flag_o_q   <= 1'b0;
      flag_f_q   <= 1'b0;
      jmp_p_q    <= 1'b0;
      rtn_p_q    <= 1'b0;
`ifdef TTLC_ICU_STACK_EN
      stk_cnt_q  <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
`endif
    end else begin
      prog_re_q <= 1'b0;
      io_we_q   <= 1'b0;
      flag_o_q  <= 1'b0;
      flag_f_q  <= 1'b0;
      jmp_p_q   <= 1'b0;
      rtn_p_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q   <= S_FETCH;
            prog_re_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          // EXEC-cycle strobes are decoded from the arriving word so they come straight from flops.
          state_q    <= S_EXEC;
          ir_q       <= prog_data;
          io_wdata_q <= rr_q ^ (op_ld == OP_STOC);
          if (!skip_q) begin
            io_we_q  <= oen_q && ((op_ld == OP_STO) || (op_ld == OP_STOC));
            flag_o_q <= (op_ld == OP_NOPO);
            flag_f_q <= (op_ld == OP_NOPF);
            jmp_p_q  <= (op_ld == OP_JMP);
            rtn_p_q  <= (op_ld == OP_RTN);
          end
        end
        S_EXEC: begin
          pc_q   <= pc_inc;
          skip_q <= 1'b0;
          if (!skip_q) begin
            rr_q <= rr_d;
            case (op_ex)
              OP_IEN: ien_q <= io_rdata;
              OP_OEN: oen_q <= io_rdata;
              OP_SKZ: skip_q <= ~rr_q;
              OP_JMP: begin
                pc_q <= ir_q[7:0];
`ifdef TTLC_ICU_STACK_EN
                for (int unsigned i = STACK_DEPTH - 1; i > 0; i--) stk_q[i] <= stk_q[i - 1];
                stk_q[0] <= pc_inc;
                if (stk_cnt_q != CW'(STACK_DEPTH)) stk_cnt_q <= stk_cnt_q + CW'(1);
`endif
              end
              OP_RTN: begin
`ifdef TTLC_ICU_STACK_EN
                if (stk_cnt_q != '0) begin
                  pc_q <= stk_q[0];
                  for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) stk_q[i] <= stk_q[i + 1];
                  stk_cnt_q <= stk_cnt_q - CW'(1);
                end else begin
                  skip_q <= 1'b1;
                end
`else
                skip_q <= 1'b1;
`endif
              end
              default: ;
            endcase
          end
          if (run) begin
            state_q   <= S_FETCH;
            prog_re_q <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
            halted_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prog_addr = pc_q;
  assign prog_re   = prog_re_q;
  assign io_addr   = ir_q[7:0];
  assign io_we     = io_we_q;
  assign io_wdata  = io_wdata_q;
  assign rr        = rr_q;
  assign ien       = ien_q;
  assign oen       = oen_q;
  assign flag_o    = flag_o_q;
  assign flag_f    = flag_f_q;
  assign jmp_p     = jmp_p_q;
  assign rtn_p     = rtn_p_q;
  assign halted    = halted_q;

endmodule
